// File: rtl/demux_2_reg.sv
// demux_2_reg: registered 1-to-2 stream demultiplexer.
// Each accepted input word goes to output slot A or B according to in_sel.
// Every output owns a one-entry holding register, so a stall on one side
// never blocks words headed for the other side.
module demux_2_reg #(
  parameter int number = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [number-1:0] in_data,
  input  logic              in_sel,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [number-1:0] out_a_data,
  output logic              out_a_valid,
  input  logic              out_a_ready,
  output logic [number-1:0] out_b_data,
  output logic              out_b_valid,
  input  logic              out_b_ready,
  output logic [CNT_W-1:0]  cnt_a,
  output logic [CNT_W-1:0]  cnt_b
);

  // Slot state: EMPTY when the valid flag is low, FULL when it is high.
  logic              vld_a_p1;
  logic              vld_b_p1;
  logic [number-1:0] data_a_p1;
  logic [number-1:0] data_b_p1;
  logic [CNT_W-1:0]  count_a;
  logic [CNT_W-1:0]  count_b;

  // Handshake and steering terms.
  logic room_a;
  logic room_b;
  logic in_fire;
  logic load_a;
  logic load_b;
  logic fire_a;
  logic fire_b;

  // Transfer counters roll over silently at 2^CNT_W.
  function automatic logic [CNT_W-1:0] wrap_inc(input logic [CNT_W-1:0] value);
    wrap_inc = value + CNT_W'(1);
  endfunction

  // A slot can take a word when it is empty or is being drained this cycle;
  // in_ready looks only at the selected slot, never at in_valid.
  always_comb begin
    room_a   = !vld_a_p1 | out_a_ready;
    room_b   = !vld_b_p1 | out_b_ready;
    in_ready = in_sel ? room_b : room_a;
    in_fire  = in_valid & in_ready;
    load_a   = in_fire & !in_sel;
    load_b   = in_fire &  in_sel;
    fire_a   = vld_a_p1 & out_a_ready;
    fire_b   = vld_b_p1 & out_b_ready;
  end

  // ---- stage p1: slot A holding register ----
  // Valid stays set on load, or while the held word is not yet taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_a_p1  <= 1'b0;
      data_a_p1 <= '0;
    end else begin
      vld_a_p1 <= load_a | (vld_a_p1 & !out_a_ready);
      if (load_a) begin
        data_a_p1 <= in_data;
      end
    end
  end

  // ---- stage p1: slot B holding register ----
  // Mirror of slot A, driven by the B-side load and ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_b_p1  <= 1'b0;
      data_b_p1 <= '0;
    end else begin
      vld_b_p1 <= load_b | (vld_b_p1 & !out_b_ready);
      if (load_b) begin
        data_b_p1 <= in_data;
      end
    end
  end

  // Count completed output handshakes; both sides may step in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_a <= '0;
      count_b <= '0;
    end else begin
      if (fire_a) begin
        count_a <= wrap_inc(count_a);
      end
      if (fire_b) begin
        count_b <= wrap_inc(count_b);
      end
    end
  end

  assign out_a_data  = data_a_p1;
  assign out_a_valid = vld_a_p1;
  assign out_b_data  = data_b_p1;
  assign out_b_valid = vld_b_p1;
  assign cnt_a       = count_a;
  assign cnt_b       = count_b;

endmodule

// File: tb/tb_demux_2_reg.sv
// Testbench for demux_2_reg: vector table plus hand-written sequences
// for throughput, async reset and counter wrap.
module tb_demux_2_reg;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_sel;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_a_data;
  logic       out_a_valid;
  logic       out_a_ready;
  logic [7:0] out_b_data;
  logic       out_b_valid;
  logic       out_b_ready;
  logic [7:0] cnt_a;
  logic [7:0] cnt_b;

  int checks = 0;
  int errors = 0;

  demux_2_reg #(.number(8), .CNT_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_sel      (in_sel),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_a_data  (out_a_data),
    .out_a_valid (out_a_valid),
    .out_a_ready (out_a_ready),
    .out_b_data  (out_b_data),
    .out_b_valid (out_b_valid),
    .out_b_ready (out_b_ready),
    .cnt_a       (cnt_a),
    .cnt_b       (cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       sel;
    logic       valid;
    logic       ra;
    logic       rb;
    logic       rdy;
    logic       av;
    logic [7:0] ad;
    logic       bv;
    logic [7:0] bd;
    logic [7:0] ca;
    logic [7:0] cb;
  } vec_t;

  vec_t vt [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // inputs | in_ready before edge | outputs after edge
    //            data   sel  vld  ra   rb   rdy  av   ad     bv   bd     ca    cb
    vt[0] = '{8'hC2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'hC2, 1'b0, 8'h00, 8'd0, 8'd0};
    vt[1] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'hC2, 1'b0, 8'h00, 8'd1, 8'd0};
    vt[2] = '{8'h29, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'hC2, 1'b1, 8'h29, 8'd1, 8'd0};
    vt[3] = '{8'hC2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'hC2, 1'b0, 8'h29, 8'd1, 8'd1};
    vt[4] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'hC2, 1'b0, 8'h29, 8'd2, 8'd1};
    vt[5] = '{8'h11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 1'b0, 8'h29, 8'd2, 8'd1};
    vt[6] = '{8'h22, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 8'h29, 8'd2, 8'd1};
    vt[7] = '{8'h33, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 1'b1, 8'h33, 8'd2, 8'd1};
    vt[8] = '{8'h22, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h22, 1'b0, 8'h33, 8'd3, 8'd2};
    vt[9] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h22, 1'b0, 8'h33, 8'd4, 8'd2};

    // Reset state
    rst_n       = 1'b0;
    in_data     = 8'h00;
    in_sel      = 1'b0;
    in_valid    = 1'b0;
    out_a_ready = 1'b0;
    out_b_ready = 1'b0;
    step();
    check("rst_a_valid", out_a_valid, 1'b0);
    check("rst_b_valid", out_b_valid, 1'b0);
    check("rst_a_data", out_a_data, 8'h00);
    check("rst_b_data", out_b_data, 8'h00);
    check("rst_cnt_a", cnt_a, 8'd0);
    check("rst_cnt_b", cnt_b, 8'd0);
    check("rst_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;

    // Table-driven: basic route, alternating stream, backpressure
    for (int i = 0; i < 10; i++) begin
      in_data     = vt[i].data;
      in_sel      = vt[i].sel;
      in_valid    = vt[i].valid;
      out_a_ready = vt[i].ra;
      out_b_ready = vt[i].rb;
      #1;
      check($sformatf("v%0d_in_ready", i), in_ready, vt[i].rdy);
      step();
      check($sformatf("v%0d_a_valid", i), out_a_valid, vt[i].av);
      check($sformatf("v%0d_a_data", i), out_a_data, vt[i].ad);
      check($sformatf("v%0d_b_valid", i), out_b_valid, vt[i].bv);
      check($sformatf("v%0d_b_data", i), out_b_data, vt[i].bd);
      check($sformatf("v%0d_cnt_a", i), cnt_a, vt[i].ca);
      check($sformatf("v%0d_cnt_b", i), cnt_b, vt[i].cb);
    end

    // Full throughput: eight B words, one per cycle, no bubbles
    for (int i = 0; i < 8; i++) begin
      in_data     = 8'(i);
      in_sel      = 1'b1;
      in_valid    = 1'b1;
      out_a_ready = 1'b1;
      out_b_ready = 1'b1;
      #1;
      check($sformatf("tp%0d_in_ready", i), in_ready, 1'b1);
      step();
      check($sformatf("tp%0d_b_valid", i), out_b_valid, 1'b1);
      check($sformatf("tp%0d_b_data", i), out_b_data, 32'(i));
    end
    in_valid = 1'b0;
    step();
    check("tp_drain_b_valid", out_b_valid, 1'b0);
    check("tp_cnt_b", cnt_b, 8'd10);

    // Async reset mid-stream with A full and stalled
    in_data     = 8'hC2;
    in_sel      = 1'b0;
    in_valid    = 1'b1;
    out_a_ready = 1'b0;
    step();
    check("ar_loaded_a_valid", out_a_valid, 1'b1);
    check("ar_loaded_a_data", out_a_data, 8'hC2);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_a_valid", out_a_valid, 1'b0);
    check("ar_a_data", out_a_data, 8'h00);
    check("ar_cnt_a", cnt_a, 8'd0);
    check("ar_cnt_b", cnt_b, 8'd0);
    check("ar_in_ready", in_ready, 1'b1);
    #1;
    rst_n       = 1'b1;
    out_a_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("ar_post%0d_a_valid", i), out_a_valid, 1'b0);
      check($sformatf("ar_post%0d_cnt_a", i), cnt_a, 8'd0);
    end

    // Counter wrap: hold one A word, stream 256 B words, release A with the last
    in_data     = 8'h5A;
    in_sel      = 1'b0;
    in_valid    = 1'b1;
    out_a_ready = 1'b0;
    out_b_ready = 1'b1;
    step();
    check("wr_a_held_valid", out_a_valid, 1'b1);
    for (int k = 0; k < 256; k++) begin
      in_data  = 8'(k);
      in_sel   = 1'b1;
      in_valid = 1'b1;
      step();
    end
    check("wr_cnt_b_255", cnt_b, 8'd255);
    check("wr_b_last_data", out_b_data, 8'hFF);
    check("wr_a_still_data", out_a_data, 8'h5A);
    check("wr_cnt_a_0", cnt_a, 8'd0);
    in_valid    = 1'b0;
    out_a_ready = 1'b1;
    step();
    check("wr_cnt_b_wrap", cnt_b, 8'd0);
    check("wr_cnt_a_1", cnt_a, 8'd1);
    check("wr_b_valid", out_b_valid, 1'b0);
    check("wr_a_valid", out_a_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_2_reg.md
Name: demux_2_reg

Overview:
Registered 1-to-2 stream demultiplexer with valid/ready handshakes on every port. It routes each accepted input word to output A or output B according to a per-word select. Each output has a one-entry holding register. It is the distribution-side counterpart of the 2:1 select mux in the pipeline datapath, used where one producer feeds two pipeline consumers, for example issue to ALU lane A or lane B.

Parameters:
number, 8, data width in bits of in_data, out_a_data and out_b_data
CNT_W, 8, width of the per-output transfer counters

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_data  input  number  input word
in_sel  input  1  destination select: 0 = A, 1 = B; stable while in_valid=1 and the word is not yet accepted
in_valid  input  1  input word valid
in_ready  output  1  block can accept the input word this cycle
out_a_data  output  number  output A word (registered)
out_a_valid  output  1  output A holds a word
out_a_ready  input  1  consumer A accepts the word
out_b_data  output  number  output B word (registered)
out_b_valid  output  1  output B holds a word
out_b_ready  input  1  consumer B accepts the word
cnt_a  output  CNT_W  number of completed A output handshakes, modulo 2^CNT_W
cnt_b  output  CNT_W  number of completed B output handshakes, modulo 2^CNT_W

Behaviour:
- Reset (rst_n=0, asynchronous, effective without a clock edge):
  - out_a_valid=0, out_b_valid=0
  - out_a_data=0, out_b_data=0
  - cnt_a=0, cnt_b=0
  - in_ready follows the combinational rule below, so it reads 1 while in reset. Any handshake attempted during reset is ignored.
- Slot state per output (X = A or B): two states, EMPTY (out_X_valid=0) and FULL (out_X_valid=1).
- Handshake definitions:
  - in_fire = in_valid & in_ready
  - X_fire = out_X_valid & out_X_ready
- in_ready is combinational: in_sel ? (!out_b_valid | out_b_ready) : (!out_a_valid | out_a_ready). There is no combinational path from in_valid to in_ready.
- Load: on in_fire, the slot selected by in_sel captures in_data at the next rising edge and sets out_X_valid=1.
  - Latency is exactly 1 cycle from input handshake to out_X_valid.
  - The unselected slot is unchanged.
- Transitions for slot X:
  - EMPTY -> FULL on load
  - FULL -> EMPTY on X_fire without load
  - FULL -> FULL with new data on X_fire plus load in the same cycle, giving one word per cycle per destination
  - FULL -> FULL holding data when there is no X_fire; the load is blocked because in_ready=0 for that destination
- Data stability: out_X_data and out_X_valid do not change while out_X_valid=1 and out_X_ready=0 (AXI-style hold).
- Independence: a stall on one output does not block words selected for the other output.
- Ordering: words to the same destination leave in input order. There is no ordering guarantee across destinations.
- Counters: cnt_X increments by 1 on each X_fire and wraps from 2^CNT_W-1 to 0 with no flag. A and B handshakes in the same cycle increment both counters.
- out_X_ready=1 while out_X_valid=0 has no effect.
- Reset mid-operation: words held in the slots are discarded and not delivered. Counters clear. Operation restarts in the EMPTY/EMPTY state after rst_n deasserts.
- No X propagation: data registers load only on in_fire.

Test Plan:
- Basic route: reset, then in_data=8'hC2, in_sel=0, in_valid=1 for one cycle with both readys=1 -> next cycle out_a_valid=1, out_a_data=8'hC2, out_b_valid=0. The following cycle out_a_valid=0 and cnt_a=1.
- Alternating stream: 8'h29 to B then 8'hC2 to A on back-to-back cycles, readys=1 -> out_b_data=8'h29 valid in cycle 1, out_a_data=8'hC2 valid in cycle 2. in_ready stays 1 throughout; cnt_a=1 and cnt_b=1.
- Backpressure: out_a_ready=0, send 8'h11 to A then 8'h22 to A:
  - 8'h11 is held in A and in_ready=0 with in_sel=0.
  - Switching in_sel=1 with 8'h33 gives in_ready=1 and 8'h33 appears on B.
  - Raising out_a_ready delivers 8'h11, then 8'h22, in order.
- Full throughput: out_b_ready=1 and 8 consecutive words 8'h00..8'h07 to B -> one word per cycle on out_b_data, no bubbles, cnt_b=8.
- Counter wrap: 256 B transfers -> cnt_b returns to 0. A concurrent A transfer in the same cycle as the 256th gives cnt_a=1.
- Async reset mid-stream: with A FULL (8'hC2) and out_a_ready=0, pulse rst_n low between clock edges -> out_a_valid=0, out_a_data=0 and counters=0 immediately. After release, 8'hC2 is never delivered.
